// File: rtl/proc_ctrl_pkg.sv
// rtl/proc_ctrl_pkg.sv - shared state encodings and ALU timer limits for proc_ctrl_fsm
package proc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LOAD_REG  = 3'd2,
        ST_ALU       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    localparam int ALU_CYCLES_MIN = 1;
    localparam int ALU_CYCLES_MAX = 16;
    // Timer holds ALU_CYCLES-1, so 4 bits cover the full legal range.
    localparam int TIMER_W = 4;

endpackage

// File: rtl/proc_ctrl_timer.sv
// rtl/proc_ctrl_timer.sv - ALU cycle down-counter: load on entry, tick while in ALU, done on last cycle
module proc_ctrl_timer
    import proc_ctrl_pkg::*;
#(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic done
);

    logic [TIMER_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= TIMER_W'(CYCLES - 1);
        end else if (tick && cnt != '0) begin
            cnt <= cnt - TIMER_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/proc_ctrl_fsm.sv
// rtl/proc_ctrl_fsm.sv - fetch/load/alu/writeback control FSM with halt handling and retire counter
module proc_ctrl_fsm
    import proc_ctrl_pkg::*;
#(
    parameter int CC_WIDTH   = 4,
    parameter int PC_WIDTH   = 8,
    parameter int ALU_CYCLES = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mem_ready,
    input  logic [CC_WIDTH-1:0]  cc_flags,
    input  logic [CC_WIDTH-1:0]  cc_mask,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic [2:0]           current_state,
    output logic                 fetch_req,
    output logic                 reg_load_en,
    output logic                 alu_en,
    output logic                 wb_en,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [CNT_WIDTH-1:0] retired,
    output logic                 halted
);

    if (ALU_CYCLES < ALU_CYCLES_MIN || ALU_CYCLES > ALU_CYCLES_MAX) begin : g_bad_alu_cycles
        $error("proc_ctrl_fsm: ALU_CYCLES out of range");
    end

    state_t state;
    state_t nxt;
    logic   halt_pend;
    logic   halt_eff;
    logic   cond_true;
    logic   alu_done;

    // A request arriving on a boundary cycle counts immediately.
    assign halt_eff  = halt_pend | halt_req;
    assign cond_true = (cc_mask == '0) || ((cc_flags & cc_mask) != '0);

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:      if (start) nxt = ST_FETCH;
                          else if (halt_eff) nxt = ST_HALT;
            ST_FETCH:     if (mem_ready) nxt = ST_LOAD_REG;
            ST_LOAD_REG:  if (cond_true) nxt = ST_ALU;
                          else nxt = halt_eff ? ST_HALT : ST_FETCH;
            ST_ALU:       if (alu_done) nxt = ST_WRITEBACK;
            ST_WRITEBACK: nxt = halt_eff ? ST_HALT : ST_FETCH;
            ST_HALT:      if (resume) nxt = ST_FETCH;
            default:      nxt = ST_IDLE;
        endcase
    end

    proc_ctrl_timer #(
        .CYCLES(ALU_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (state == ST_LOAD_REG && nxt == ST_ALU),
        .tick (state == ST_ALU),
        .done (alu_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= '0;
            retired   <= '0;
            halt_pend <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt == ST_HALT && state != ST_HALT) begin
                halt_pend <= 1'b0;
            end else if (state != ST_HALT && halt_req) begin
                halt_pend <= 1'b1;
            end
            if (state == ST_FETCH && mem_ready) begin
                pc <= pc + PC_WIDTH'(1);
            end
            if (state == ST_WRITEBACK && retired != '1) begin
                retired <= retired + CNT_WIDTH'(1);
            end
        end
    end

    assign current_state = state;
    assign fetch_req     = (state == ST_FETCH);
    assign reg_load_en   = (state == ST_LOAD_REG);
    assign alu_en        = (state == ST_ALU);
    assign wb_en         = (state == ST_WRITEBACK);
    assign halted        = (state == ST_HALT);

endmodule

// File: doc/proc_ctrl_fsm.md
PROC_CTRL_FSM -- requirements
Module: proc_ctrl_fsm

Interface
REQ-001 Parameter CC_WIDTH, default 4: width of condition-code flags and mask.
REQ-002 Parameter PC_WIDTH, default 8: program-counter width.
REQ-003 Parameter ALU_CYCLES, default 2, legal range 1..16: clock cycles spent in ALU per instruction.
REQ-004 Parameter CNT_WIDTH, default 16: retired-instruction counter width.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  begin or continue execution from IDLE.
REQ-008 mem_ready  input  1  instruction memory has returned the fetch word this cycle.
REQ-009 cc_flags  input  CC_WIDTH  current condition-code flags.
REQ-010 cc_mask  input  CC_WIDTH  condition select for the current instruction; all-zero means unconditional.
REQ-011 halt_req  input  1  single-cycle request to stop at the next instruction boundary.
REQ-012 resume  input  1  leave HALT.
REQ-013 current_state  output  3  encoded FSM state.
REQ-014 fetch_req, reg_load_en, alu_en, wb_en  output  1 each  per-state strobes.
REQ-015 pc  output  PC_WIDTH  fetch address.
REQ-016 retired  output  CNT_WIDTH  count of instructions completed through WRITEBACK.
REQ-017 halted  output  1  high while in HALT.

Function
REQ-018 States SHALL be IDLE=0, FETCH=1, LOAD_REG=2, ALU=3, WRITEBACK=4, HALT=5; codes 6-7 SHALL go to IDLE on the next edge.
REQ-019 IDLE: start=1 -> FETCH; otherwise stay.
REQ-020 FETCH: fetch_req=1; mem_ready=1 -> LOAD_REG with pc incremented by 1 on the same edge; mem_ready=0 -> stay (stall), pc unchanged.
REQ-021 pc SHALL wrap from 2^PC_WIDTH-1 to 0.
REQ-022 LOAD_REG: reg_load_en=1; condition true when cc_mask=0 or (cc_flags & cc_mask) != 0.
REQ-023 LOAD_REG, condition true -> ALU; condition false -> FETCH, or HALT if a halt is pending; skipped instructions do not increment retired.
REQ-024 ALU: alu_en=1 for exactly ALU_CYCLES consecutive cycles, timed by an internal down-counter loaded on entry; the last cycle -> WRITEBACK.
REQ-025 WRITEBACK: wb_en=1 for one cycle; retired increments by 1 and saturates at all-ones; -> HALT if a halt is pending, else FETCH.
REQ-026 halt_req SHALL be latched into a sticky pending flag in any state except HALT. The flag is cleared on entry to HALT.
REQ-027 A halt pending in IDLE SHALL move IDLE -> HALT on the next edge, unless start=1 in the same cycle. Start wins; the flag stays pending until the next boundary.
REQ-028 HALT: halted=1, all strobes 0; resume=1 -> FETCH with pc and retired preserved; halt_req arriving in HALT SHALL be ignored.
REQ-029 halt_req and resume in the same cycle in HALT: resume wins, halt_req dropped.
REQ-030 Strobes, halted and current_state SHALL be decoded from the state register only (Moore); exactly one strobe or halted is high in each non-IDLE state; all are 0 in IDLE.
REQ-031 Transition latency SHALL be one edge: input sampled at edge N, new current_state visible after edge N.
REQ-032 start is ignored outside IDLE; deasserting start mid-instruction SHALL NOT abort the loop.

Reset
REQ-033 rst=1 SHALL immediately force current_state=IDLE, pc=0, retired=0, ALU counter=0 and pending halt=0; all strobes and halted SHALL be 0.
REQ-034 Reset asserted mid-ALU or mid-stall SHALL abandon the instruction with no retired increment.
REQ-035 After rst falls, the first transition SHALL occur on the next rising edge.

Structure
REQ-036 State encodings and the ALU_CYCLES legal range SHALL live in a shared package proc_ctrl_pkg.
REQ-037 The ALU cycle timer SHALL be a sub-module proc_ctrl_timer (load, count-down, done); all else in proc_ctrl_fsm.

Verification
REQ-038 start=1 from IDLE, mem_ready=1, cc_mask=0, ALU_CYCLES=2 -> states 1,2,3,3,4,1 repeating; retired=1 after the first WRITEBACK.
REQ-039 mem_ready held 0 for 3 cycles in FETCH -> FETCH held 3 extra cycles, pc constant, then pc+1 on the ready edge.
REQ-040 cc_mask=4'b0010, cc_flags=4'b0001 -> LOAD_REG -> FETCH, retired unchanged; cc_flags=4'b0010 -> ALU.
REQ-041 halt_req pulse during ALU -> completes ALU and WRITEBACK, then HALT with halted=1; resume -> FETCH with pc continuous.
REQ-042 PC_WIDTH=4, pc=15, fetch -> pc=0; CNT_WIDTH=2 after 5 retirements -> retired=3.
REQ-043 rst asserted between clock edges in ALU -> current_state=0 and all outputs 0 before the next edge.
